// File: rtl/ppa_accum_pkg.sv
// Shared types and constants for the ppa_stream_accum burst accumulator.
package ppa_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int DEF_WIDTH = 21;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_WIDTH-1:0] SAT_VAL = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/sklansky_prefix_add.sv
// Combinational WIDTH-bit adder built on a Sklansky generate/propagate prefix tree.
module sklansky_prefix_add #(
  parameter int WIDTH = 21
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Level k holds group (g, p) spanning from bit i down to the start of its 2^k block.
  wire [WIDTH-1:0] g [LEVELS+1];
  wire [WIDTH-1:0] p [LEVELS+1];
  wire [WIDTH:0]   c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> l) % 2) == 1) begin : g_merge
        localparam int J = ((i >> l) << l) - 1;
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
        assign p[l+1][i] = p[l][i] & p[l][J];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign c[0]       = cin;
  assign c[WIDTH:1] = g[LEVELS] | (p[LEVELS] & {WIDTH{cin}});
  assign sum        = p[0] ^ c[WIDTH-1:0];
  assign cout       = c[WIDTH];

endmodule

// File: rtl/ppa_stream_accum.sv
// Valid/ready burst accumulator around a Sklansky prefix adder.
// Define ACC_SAT_EN to saturate the sum at all-ones on adder carry-out instead of wrapping.
module ppa_stream_accum
  import ppa_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] acc_next;
  logic             beat;

  sklansky_prefix_add #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ACC_SAT_EN
  assign acc_next = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
  assign acc_next = add_sum;
`endif

  assign beat    = in_valid && in_ready;
  assign out_sum = acc;

  // in_ready, out_valid and busy are registered alongside state so they change only on edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_carry <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            out_carry <= 1'b0;
            busy      <= 1'b1;
            if (len != '0) begin
              count    <= len;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc       <= acc_next;
            out_carry <= out_carry | add_cout;
            count     <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppa_stream_accum.sv
// Self-checking bench for ppa_stream_accum: directed bursts plus a random regression
// checked against a queue of expected results computed from plain integer sums.
module tb_ppa_stream_accum;
  import ppa_accum_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int CW = DEF_CNT_W;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
  } result_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] op_buf [256];
  result_t      exp_q [$];

  ppa_stream_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: add in a W+1 bit integer, note any carry, wrap or saturate.
  function automatic result_t model(input int n);
    result_t      r;
    logic [W:0]   t;
    r.sum   = '0;
    r.carry = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, r.sum} + {1'b0, op_buf[i]};
      if (t[W]) r.carry = 1'b1;
`ifdef ACC_SAT_EN
      r.sum = t[W] ? SAT_VAL : t[W-1:0];
`else
      r.sum = t[W-1:0];
`endif
    end
    return r;
  endfunction

  // Compare process: whenever a result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        check("stream_sum", 32'(out_sum), 32'(exp_q[0].sum));
        check("stream_carry", 32'(out_carry), 32'(exp_q[0].carry));
        check("in_ready_while_valid", 32'(in_ready), 32'd0);
        check("busy_while_valid", 32'(busy), 32'd1);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic start_burst(input int n);
    exp_q.push_back(model(n));
    start = 1'b1;
    len   = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input int bubbles);
    int t = 0;
    if (bubbles > 0) begin
      in_valid = 1'b0;
      repeat (bubbles) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("beat_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
  endtask

  task automatic wait_result(input int stall);
    int t = 0;
    out_ready = 1'b0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_burst(input int n, input int bubble_max, input int stall);
    start_burst(n);
    for (int i = 0; i < n; i++) send(op_buf[i], $urandom_range(bubble_max, 0));
    in_valid = 1'b0;
    wait_result(stall);
  endtask

  initial begin
    result_t r;
    int      bub [4];

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Model pinned against hand-computed literals
    op_buf[0] = 21'd1; op_buf[1] = 21'd2; op_buf[2] = 21'd3;
    r = model(3);
    check("model_basic_sum", 32'(r.sum), 32'd6);
    check("model_basic_carry", 32'(r.carry), 32'd0);

    // Basic burst with in_valid held high; out_valid one cycle after the last beat
    start_burst(3);
    check("accum_in_ready", 32'(in_ready), 32'd1);
    check("accum_busy", 32'(busy), 32'd1);
    send(op_buf[0], 0);
    send(op_buf[1], 0);
    check("no_valid_before_last", 32'(out_valid), 32'd0);
    send(op_buf[2], 0);
    in_valid = 1'b0;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("latency_in_ready", 32'(in_ready), 32'd0);
    check("basic_sum", 32'(out_sum), 32'd6);
    check("basic_carry", 32'(out_carry), 32'd0);
    wait_result(0);

    // Wrap (or saturate) on carry-out
    op_buf[0] = 21'h1FFFFF; op_buf[1] = 21'h000002;
    r = model(2);
`ifdef ACC_SAT_EN
    check("model_wrap_sum", 32'(r.sum), 32'h1FFFFF);
`else
    check("model_wrap_sum", 32'(r.sum), 32'h000001);
`endif
    check("model_wrap_carry", 32'(r.carry), 32'd1);
    start_burst(2);
    send(op_buf[0], 0);
    send(op_buf[1], 0);
    in_valid = 1'b0;
`ifdef ACC_SAT_EN
    check("wrap_sum", 32'(out_sum), 32'h1FFFFF);
`else
    check("wrap_sum", 32'(out_sum), 32'h000001);
`endif
    check("wrap_carry", 32'(out_carry), 32'd1);
    wait_result(0);

    // Bubbles on input, then 5 cycles of output backpressure
    op_buf[0] = 21'd10; op_buf[1] = 21'd20; op_buf[2] = 21'd30; op_buf[3] = 21'd40;
    bub = '{1, 2, 0, 1};
    start_burst(4);
    for (int i = 0; i < 4; i++) send(op_buf[i], bub[i]);
    in_valid = 1'b0;
    check("bubble_sum", 32'(out_sum), 32'd100);
    wait_result(5);

    // Empty burst returns zero straight away
    start_burst(0);
    check("empty_out_valid", 32'(out_valid), 32'd1);
    check("empty_sum", 32'(out_sum), 32'd0);
    check("empty_carry", 32'(out_carry), 32'd0);
    wait_result(0);

    // Start during ACCUM is ignored
    op_buf[0] = 21'd7; op_buf[1] = 21'd8;
    start_burst(2);
    send(op_buf[0], 0);
    in_valid = 1'b0;
    start = 1'b1;
    len   = CW'(9);
    @(negedge clk);
    start = 1'b0;
    send(op_buf[1], 0);
    in_valid = 1'b0;
    check("ignored_start_sum", 32'(out_sum), 32'd15);
    wait_result(0);
    check("no_queued_start", 32'(busy), 32'd0);

    // Reset mid-burst clears outputs asynchronously
    for (int i = 0; i < 5; i++) op_buf[i] = 21'(100 + i);
    start_burst(5);
    send(op_buf[0], 0);
    send(op_buf[1], 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random regression, back-to-back bursts
    for (int b = 0; b < 50; b++) begin
      int n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++)
        op_buf[i] = (b % 2 == 1) ? W'($urandom_range(32'h1FFFFF, 0))
                                 : W'($urandom_range(32'hFFF, 0));
      run_burst(n, (b % 3 == 0) ? 0 : 2, $urandom_range(2, 0));
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
